// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared state encoding and op constants for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

endpackage

// File: rtl/lsu_timeout_ctr.sv
// rtl/lsu_timeout_ctr.sv - REQ-phase watchdog: flags the cycle in which TIMEOUT_CYC un-acked cycles elapse
module lsu_timeout_ctr #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic ack,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!active || ack) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Fires in the TIMEOUT_CYC-th consecutive waiting cycle so mem_req is high exactly that long
    assign expired = active && !ack && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - burst load/store engine between front end, register file and memory
// Optional watchdog: define LSU_TIMEOUT_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 16,
    parameter int NUM_REGS    = 4,
    parameter int MAX_BURST   = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        op_valid,
    output logic                        op_ready,
    input  logic                        op_store,
    input  logic [$clog2(NUM_REGS)-1:0] op_reg,
    input  logic [ADDR_W-1:0]           op_addr,
    input  logic [((MAX_BURST > 1) ? $clog2(MAX_BURST) : 1)-1:0] op_len,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic                        mem_ack,
    output logic [$clog2(NUM_REGS)-1:0] reg_rd_idx,
    input  logic [DATA_W-1:0]           reg_rd_data,
    output logic                        reg_wr_en,
    output logic [$clog2(NUM_REGS)-1:0] reg_wr_idx,
    output logic [DATA_W-1:0]           reg_wr_data,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int REG_W = $clog2(NUM_REGS);
    localparam int LEN_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    lsu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [REG_W-1:0]  cur_reg_q;
    logic [LEN_W-1:0]  beats_left_q;
    logic              store_q;
    logic [DATA_W-1:0] rdata_q;
    logic              capture, advance, latch;
    logic              timeout_hit;

`ifdef LSU_TIMEOUT_EN
    logic err_q;

    lsu_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (state_q == REQ),
        .ack     (mem_ack),
        .expired (timeout_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        advance = 1'b0;
        latch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    capture = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    if (store_q == OP_STORE) begin
                        if (beats_left_q == '0) begin
                            state_d = DONE;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        latch   = 1'b1;
                        state_d = WB;
                    end
                end else if (timeout_hit) begin
                    state_d = DONE;
                end
            end
            WB: begin
                if (beats_left_q == '0) begin
                    state_d = DONE;
                end else begin
                    advance = 1'b1;
                    state_d = REQ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr_q   <= '0;
            cur_reg_q    <= '0;
            beats_left_q <= '0;
            store_q      <= OP_LOAD;
            rdata_q      <= '0;
        end else begin
            if (capture) begin
                cur_addr_q   <= op_addr;
                cur_reg_q    <= op_reg;
                // A single-beat build has no meaningful length field
                beats_left_q <= (MAX_BURST > 1) ? op_len : '0;
                store_q      <= op_store;
            end else if (advance) begin
                cur_addr_q   <= cur_addr_q + 1'b1;
                cur_reg_q    <= cur_reg_q + 1'b1;
                beats_left_q <= beats_left_q - 1'b1;
            end
            if (latch) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign op_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign mem_req     = (state_q == REQ);
    assign mem_we      = mem_req && (store_q == OP_STORE);
    assign mem_addr    = mem_req ? cur_addr_q : '0;
    assign mem_wdata   = mem_we ? reg_rd_data : '0;
    assign reg_rd_idx  = (state_q == IDLE) ? op_reg : cur_reg_q;
    assign reg_wr_en   = (state_q == WB);
    assign reg_wr_idx  = reg_wr_en ? cur_reg_q : '0;
    assign reg_wr_data = reg_wr_en ? rdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

`ifdef LSU_TIMEOUT_EN
    localparam int TO_CYC = 8;
`else
    localparam int TO_CYC = 64;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid, op_ready, op_store;
    logic [1:0]  op_reg;
    logic [15:0] op_addr;
    logic [1:0]  op_len;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [1:0]  reg_rd_idx, reg_wr_idx;
    logic [7:0]  reg_rd_data, reg_wr_data;
    logic        reg_wr_en, busy, done, err;

    logic [7:0]  mem [0:65535];
    logic [7:0]  rf [0:3];
    logic [15:0] ack_addr_q [$];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    bit          mem_hang = 1'b0;
    logic        resp_ack = 1'b0;
    logic        spur_ack = 1'b0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          pass_cnt = 0;
    int          fail_cnt = 0;
    int          total_cnt = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYC(TO_CYC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_store    (op_store),
        .op_reg      (op_reg),
        .op_addr     (op_addr),
        .op_len      (op_len),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .reg_rd_idx  (reg_rd_idx),
        .reg_rd_data (reg_rd_data),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_idx  (reg_wr_idx),
        .reg_wr_data (reg_wr_data),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    assign reg_rd_data = rf[reg_rd_idx];
    assign mem_ack     = resp_ack | spur_ack;

    // Memory model: acks the (ack_delay+1)-th REQ cycle of each beat
    always @(negedge clk) begin
        resp_ack = 1'b0;
        if (mem_req && !mem_hang) begin
            if (wait_cnt >= ack_delay) begin
                resp_ack  = 1'b1;
                mem_rdata = mem[mem_addr];
                ack_addr_q.push_back(mem_addr);
                if (mem_we) mem[mem_addr] = mem_wdata;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (reg_wr_en) begin
            rf[reg_wr_idx] = reg_wr_data;
            wr_cnt++;
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic offer(input logic st, input logic [1:0] r, input logic [15:0] a, input logic [1:0] l);
        op_valid = 1'b1;
        op_store = st;
        op_reg   = r;
        op_addr  = a;
        op_len   = l;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n;
        n = 0;
        while (!done && n < bound) begin
            tick();
            n++;
        end
        check(tag, {31'd0, done}, 32'd1);
        tick();
    endtask

    initial begin
        int wr0, dn0, req_cycles;
        rst_n = 1'b0; op_valid = 1'b0; op_store = 1'b0;
        op_reg = '0; op_addr = '0; op_len = '0; mem_rdata = '0;
        for (int i = 0; i < 4; i++) rf[i] = '0;
        mem[16'h0010] = 8'hA5;
        mem[16'hFFFF] = 8'h5A;
        mem[16'h0000] = 8'h3C;
        tick();
        check("rst_op_ready", {31'd0, op_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_reg_wr_en", {31'd0, reg_wr_en}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single LOAD: REQ c1, WB c2, done c3
        offer(1'b0, 2'd2, 16'h0010, 2'd0);
        tick();
        op_valid = 1'b0;
        check("ld_c1_req", {31'd0, mem_req}, 32'd1);
        check("ld_c1_addr", {16'd0, mem_addr}, 32'h0010);
        check("ld_c1_we", {31'd0, mem_we}, 32'd0);
        check("ld_c1_ready", {31'd0, op_ready}, 32'd0);
        tick();
        check("ld_c2_wr_en", {31'd0, reg_wr_en}, 32'd1);
        check("ld_c2_wr_idx", {30'd0, reg_wr_idx}, 32'd2);
        check("ld_c2_wr_data", {24'd0, reg_wr_data}, 32'hA5);
        tick();
        check("ld_c3_done", {31'd0, done}, 32'd1);
        check("ld_c3_wr_en", {31'd0, reg_wr_en}, 32'd0);
        tick();
        check("ld_c4_done", {31'd0, done}, 32'd0);
        check("ld_c4_ready", {31'd0, op_ready}, 32'd1);
        check("ld_wr_cnt", wr_cnt, 32'd1);

        // Burst STORE with register index wrap 3->0
        rf[0] = 8'd11; rf[1] = 8'd22; rf[2] = 8'd33; rf[3] = 8'd44;
        dn0 = done_cnt;
        offer(1'b1, 2'd3, 16'h0100, 2'd3);
        tick();
        op_valid = 1'b0;
        check("st_we", {31'd0, mem_we}, 32'd1);
        wait_done("st_done", 20);
        check("st_m100", {24'd0, mem[16'h0100]}, 32'd44);
        check("st_m101", {24'd0, mem[16'h0101]}, 32'd11);
        check("st_m102", {24'd0, mem[16'h0102]}, 32'd22);
        check("st_m103", {24'd0, mem[16'h0103]}, 32'd33);
        check("st_done_cnt", done_cnt - dn0, 32'd1);

        // Wait states and address wrap
        ack_addr_q.delete();
        ack_delay = 5;
        wr0 = wr_cnt;
        offer(1'b0, 2'd0, 16'hFFFF, 2'd1);
        tick();
        op_valid = 1'b0;
        check("ws_c1_addr", {16'd0, mem_addr}, 32'hFFFF);
        tick(); tick(); tick();
        check("ws_c4_req", {31'd0, mem_req}, 32'd1);
        check("ws_c4_addr", {16'd0, mem_addr}, 32'hFFFF);
        check("ws_c4_ack", {31'd0, mem_ack}, 32'd0);
        wait_done("ws_done", 40);
        check("ws_ack_cnt", ack_addr_q.size(), 32'd2);
        if (ack_addr_q.size() == 2) begin
            check("ws_addr0", {16'd0, ack_addr_q[0]}, 32'hFFFF);
            check("ws_addr1", {16'd0, ack_addr_q[1]}, 32'h0000);
        end
        check("ws_wr_cnt", wr_cnt - wr0, 32'd2);
        check("ws_rf0", {24'd0, rf[0]}, 32'h5A);
        check("ws_rf1", {24'd0, rf[1]}, 32'h3C);
        ack_delay = 0;

        // Spurious ack in IDLE, then op_valid held through a busy op
        wr0 = wr_cnt;
        spur_ack = 1'b1;
        tick();
        spur_ack = 1'b0;
        check("spur_busy", {31'd0, busy}, 32'd0);
        check("spur_wr_cnt", wr_cnt - wr0, 32'd0);
        offer(1'b0, 2'd1, 16'h0010, 2'd0);
        tick();
        check("hs_c1_ready", {31'd0, op_ready}, 32'd0);
        tick();
        check("hs_c2_ready", {31'd0, op_ready}, 32'd0);
        tick();
        check("hs_c3_done", {31'd0, done}, 32'd1);
        check("hs_c3_ready", {31'd0, op_ready}, 32'd0);
        tick();
        check("hs_c4_ready", {31'd0, op_ready}, 32'd1);
        check("hs_c4_busy", {31'd0, busy}, 32'd0);
        tick();
        op_valid = 1'b0;
        check("hs_c5_req", {31'd0, mem_req}, 32'd1);
        wait_done("hs_done2", 20);

        // Reset during the third REQ of a 4-beat LOAD
        wr0 = wr_cnt;
        dn0 = done_cnt;
        offer(1'b0, 2'd0, 16'h0030, 2'd3);
        tick();
        op_valid = 1'b0;
        tick(); tick(); tick(); tick();
        check("rm_req_before", {31'd0, mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rm_req_async", {31'd0, mem_req}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("rm_wr_cnt", wr_cnt - wr0, 32'd2);
        check("rm_done_cnt", done_cnt - dn0, 32'd0);
        check("rm_ready", {31'd0, op_ready}, 32'd1);

`ifdef LSU_TIMEOUT_EN
        mem_hang = 1'b1;
        dn0 = done_cnt;
        req_cycles = 0;
        offer(1'b1, 2'd0, 16'h0200, 2'd3);
        tick();
        op_valid = 1'b0;
        while (mem_req && req_cycles < 30) begin
            req_cycles++;
            tick();
        end
        check("to_req_cycles", req_cycles, 32'd8);
        check("to_done", {31'd0, done}, 32'd1);
        check("to_err", {31'd0, err}, 32'd1);
        tick(); tick(); tick();
        check("to_err_sticky", {31'd0, err}, 32'd1);
        check("to_done_cnt", done_cnt - dn0, 32'd1);
        mem_hang = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("to_err_cleared", {31'd0, err}, 32'd0);
`else
        req_cycles = 0;
        check("err_tied", {31'd0, err}, 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
